// File: rtl/signed_accum_pkg.sv
// signed_accum_pkg: shared state encoding, mode constants and saturation bounds for signed_sat_accum
package signed_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;
  // Bounds returned 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/signed_sat_accum_sat_add.sv
// sat_add: combinational signed add of two WIDTH-bit operands with overflow flag
//   a, b : signed operands
//   y    : clamped sum (SAT_ARITH_EN defined) or wrapped WIDTH LSBs (undefined)
//   ovf  : true sum lies outside the signed WIDTH-bit range
module sat_add
  import signed_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);
  logic [WIDTH:0] s;
  assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  // The extra sign bit disagrees with the result MSB exactly when the sum left the range.
  assign ovf = s[WIDTH] != s[WIDTH-1];
`ifdef SAT_ARITH_EN
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));
  assign y = ovf ? (s[WIDTH] ? MIN_V : MAX_V) : s[WIDTH-1:0];
`else
  assign y = s[WIDTH-1:0];
`endif
endmodule

// File: rtl/signed_sat_accum.sv
// signed_sat_accum: registered signed adder / NUM_SAMPLES-beat accumulator with valid/ready and overflow flag
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_a, in_b, mode (0 add, 1 accumulate; sampled on first beat of a run)
//   out_valid/out_ready, sum, overflow (sticky within a run), beat_cnt
//   SAT_ARITH_EN defined selects saturation; undefined selects two's-complement wrap.
module signed_sat_accum
  import signed_accum_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] sum,
  output logic                    overflow,
  output logic [CNT_W-1:0]        beat_cnt
);
  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d, pair_y, acc_y;
  logic                    ovf_q, ovf_d, out_valid_q, out_valid_d, pair_ovf, acc_ovf;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    in_acc, out_acc, last;
  sat_add #(.WIDTH(WIDTH)) u_pair (.a(in_a),  .b(in_b),   .y(pair_y), .ovf(pair_ovf));
  sat_add #(.WIDTH(WIDTH)) u_acc  (.a(acc_q), .b(pair_y), .y(acc_y),  .ovf(acc_ovf));
  assign in_ready  = state_q != HOLD;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign beat_cnt  = beat_cnt_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid_q && out_ready;
  // acc_q is zero in IDLE, so the accumulator adder also serves the first beat of a run.
  assign last      = (state_q == IDLE) ? (NUM_SAMPLES == 1) : (beat_cnt_q == CNT_W'(NUM_SAMPLES - 1));
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;
    if (state_q == IDLE && in_acc && mode == MODE_ADD) begin
      sum_d       = pair_y;
      ovf_d       = pair_ovf;
      out_valid_d = 1'b1;
      state_d     = HOLD;
    end else if (in_acc && (state_q == ACCUM || mode == MODE_ACC)) begin
      acc_d       = acc_y;
      ovf_d       = (state_q == ACCUM && ovf_q) || pair_ovf || acc_ovf;
      beat_cnt_d  = (state_q == IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
      sum_d       = last ? acc_y : sum_q;
      out_valid_d = last;
      state_d     = last ? HOLD : ACCUM;
    end else if (state_q == HOLD && out_acc) begin
      out_valid_d = 1'b0;
      beat_cnt_d  = '0;
      acc_d       = '0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_signed_sat_accum.sv
// tb_signed_sat_accum: scoreboard bench for signed_sat_accum (WIDTH=8, NUM_SAMPLES=4)
module tb_signed_sat_accum;
  logic              clk, rst, in_valid, in_ready, mode, out_valid, out_ready, overflow;
  logic signed [7:0] in_a, in_b, sum;
  logic [2:0]        beat_cnt;
  int                total = 0;
  int                bad = 0;
  logic [8:0]        exp_q[$];
  signed_sat_accum #(.WIDTH(8), .NUM_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow),
    .beat_cnt(beat_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [8:0] m_add(input logic signed [7:0] a, input logic signed [7:0] b);
    int s = int'(a) + int'(b);
    logic ov = (s > 127) || (s < -128);
`ifdef SAT_ARITH_EN
    logic [7:0] y = (s > 127) ? 8'h7f : (s < -128) ? 8'h80 : 8'(s);
`else
    logic [7:0] y = 8'(s);
`endif
    return {ov, y};
  endfunction
  task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b, input logic m);
    in_a = a; in_b = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic wait_out(output bit to);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    to = !out_valid;
  endtask
  task automatic test_reset();
    total++; if (sum !== 8'sd0) begin bad++; $display("FAIL rst_sum: got %0d want 0", sum); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    beat(8'sd1, 8'sd1, 1'b1);
    beat(8'sd2, 8'sd2, 1'b1);
    total++; if (beat_cnt !== 3'd2) begin bad++; $display("FAIL mid_beat_cnt: got %0d want 2", beat_cnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL async_beat_cnt: got %0d want 0", beat_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
    total++; if (sum !== 8'sd0) begin bad++; $display("FAIL async_sum: got %0d want 0", sum); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_add();
    logic [8:0] e;
    exp_q.push_back(m_add(-8'sd5, 8'sd3));
    beat(-8'sd5, 8'sd3, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_in_ready: got %b want 0", in_ready); end
    e = exp_q.pop_front();
    total++; if (sum !== e[7:0]) begin bad++; $display("FAIL add_sum: got %0d want %0d", sum, $signed(e[7:0])); end
    total++; if (overflow !== e[8]) begin bad++; $display("FAIL add_ovf: got %b want %b", overflow, e[8]); end
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL add_beat_cnt: got %0d want 0", beat_cnt); end
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_release: out_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_release_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_saturation();
    logic signed [7:0] ta[6] = '{8'sd100, -8'sd100, 8'sd127, -8'sd64, 8'sd63, -8'sd128};
    logic signed [7:0] tb[6] = '{8'sd100, -8'sd100, -8'sd128, -8'sd64, 8'sd64, -8'sd1};
    logic [8:0] e;
    bit to;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(m_add(ta[i], tb[i]));
      beat(ta[i], tb[i], 1'b0);
      wait_out(to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL sat_timeout[%0d]: out_valid never rose", i); end
      total++; if (sum !== e[7:0]) begin bad++; $display("FAIL sat_sum[%0d]: got %0d want %0d", i, sum, $signed(e[7:0])); end
      total++; if (overflow !== e[8]) begin bad++; $display("FAIL sat_ovf[%0d]: got %b want %b", i, overflow, e[8]); end
      drain();
    end
  endtask
  task automatic test_accum(input logic signed [7:0] ta[4], input logic signed [7:0] tb[4]);
    logic [8:0] p, r, e;
    logic signed [7:0] acc = 0;
    logic ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = m_add(ta[i], tb[i]);
      r = m_add(acc, p[7:0]);
      acc = r[7:0];
      ov = ov | p[8] | r[8];
    end
    exp_q.push_back({ov, acc});
    for (int i = 0; i < 4; i++) begin
      beat(ta[i], tb[i], (i == 0) ? 1'b1 : 1'b0);
      total++; if (beat_cnt !== 3'(i + 1)) begin bad++; $display("FAIL acc_beat_cnt[%0d]: got %0d want %0d", i, beat_cnt, i + 1); end
      total++; if (out_valid !== (i == 3)) begin bad++; $display("FAIL acc_out_valid[%0d]: got %b want %b", i, out_valid, i == 3); end
    end
    e = exp_q.pop_front();
    total++; if (sum !== e[7:0]) begin bad++; $display("FAIL acc_sum: got %0d want %0d", sum, $signed(e[7:0])); end
    total++; if (overflow !== e[8]) begin bad++; $display("FAIL acc_ovf: got %b want %b", overflow, e[8]); end
    drain();
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL acc_cnt_clear: got %0d want 0", beat_cnt); end
  endtask
  task automatic test_back_pressure();
    logic [8:0] e;
    exp_q.push_back(m_add(8'sd7, -8'sd9));
    beat(8'sd7, -8'sd9, 1'b0);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_a = 8'sd50; in_b = 8'sd50; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (sum !== e[7:0]) begin bad++; $display("FAIL bp_sum[%0d]: got %0d want %0d", i, sum, $signed(e[7:0])); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: out_valid got %b want 0", out_valid); end
    exp_q.push_back(m_add(8'sd1, 8'sd2));
    beat(8'sd1, 8'sd2, 1'b0);
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    total++; if (sum !== e[7:0]) begin bad++; $display("FAIL bp_next_sum: got %0d want %0d", sum, $signed(e[7:0])); end
    drain();
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_add();
    test_saturation();
    test_accum('{8'sd10, 8'sd10, 8'sd10, 8'sd10}, '{8'sd5, 8'sd5, 8'sd5, 8'sd5});
    test_back_pressure();
    test_accum('{8'sd100, 8'sd10, -8'sd5, 8'sd1}, '{8'sd20, 8'sd0, 8'sd0, 8'sd0});
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/signed_sat_accum.md
Name: signed_sat_accum

Overview:
Parametrised, registered successor to the team's combinational signed adder. It adds two signed operands per accepted beat using valid/ready handshakes on input and output. It runs in one of two modes: single-shot add, or accumulation of a run of NUM_SAMPLES beats. Results saturate, and an overflow flag is reported. It sits between a signed sample source and any downstream consumer that needs back-pressure.

Parameters:
WIDTH, 8, bit width of operands and result (two's complement, >= 2)
NUM_SAMPLES, 4, beats summed per result in accumulate mode (>= 1)
CNT_W, $clog2(NUM_SAMPLES+1), width of the beat counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  signed operand A
in_b  input  WIDTH  signed operand B
mode  input  1  0 = add, 1 = accumulate; sampled on the first beat of a run
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  signed result
overflow  output  1  a saturation/wrap event occurred while forming this result
beat_cnt  output  CNT_W  beats accepted in the current accumulate run

Behaviour:
- Reset (async assert, released synchronously to clk): state=IDLE, sum=0, overflow=0, out_valid=0, beat_cnt=0, internal acc=0, in_ready=1.
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD.
- States:
  - IDLE: on accept with mode=0, register sat(a+b) into sum, set out_valid, go to HOLD. Latency is 1 cycle.
  - IDLE: on accept with mode=1, acc=sat(a+b), beat_cnt=1. If NUM_SAMPLES==1, go to HOLD with sum=acc. Otherwise go to ACCUM.
  - ACCUM: each accept sets acc=sat(acc+sat(a+b)) and increments beat_cnt. The mode pin is ignored. On the NUM_SAMPLES-th beat, sum=result, out_valid=1, go to HOLD.
  - HOLD: sum, overflow and out_valid stay stable until output accept. On accept, out_valid=0, beat_cnt=0, acc=0, go to IDLE. There is no same-cycle turnaround: a new input is accepted at the earliest on the cycle after the output accept.
- Arithmetic: sign-extend operands to WIDTH+1 bits and add.
  - Result > 2^(WIDTH-1)-1 clamps to the maximum; result < -2^(WIDTH-1) clamps to the minimum.
  - overflow is the sticky OR of every clamp event within the run. It is cleared on the next run start.
- in_valid is ignored while in_ready=0. Operand changes without in_valid have no effect.
- Reset mid-run discards the partial accumulation and beat_cnt immediately.

Optional Feature:
SAT_ARITH_EN
- Defined: saturating arithmetic as above.
- Undefined: two's-complement wrap-around (the WIDTH LSBs of the sum). overflow still flags any step whose true result falls outside the range, so the wrap is observable.

Decomposition:
- Package signed_accum_pkg holds:
  - state enum IDLE/ACCUM/HOLD, 2 bits
  - MODE_ADD=0 and MODE_ACC=1 constants
  - max/min helper functions for a given WIDTH
- One natural sub-module, sat_add: combinational, parametrised WIDTH, inputs a and b, outputs y and ovf. It is instantiated twice: operand sum, and accumulator update.

Test Plan:
- Reset: assert rst mid-ACCUM after 2 beats -> sum=0, out_valid=0, beat_cnt=0, in_ready=1 asynchronously.
- Add mode: in_a=-5, in_b=3, mode=0 -> one cycle later sum=-2, overflow=0, out_valid=1, in_ready=0.
- Saturation, WIDTH=8: 100+100 -> sum=127, overflow=1. -100+(-100) -> sum=-128, overflow=1. Without SAT_ARITH_EN: sum=-56 and 56, overflow=1.
- Accumulate, NUM_SAMPLES=4: four beats of (10,5) -> beat_cnt steps 1,2,3,4; sum=60; out_valid on the cycle after beat 4.
- Back-pressure: hold out_ready=0 for 5 cycles -> sum stable, in_ready=0, extra in_valid pulses ignored. On out_ready=1, out_valid drops next cycle and the next add is accepted.
- Accumulator clamp mid-run: beats (100,20),(10,0),(-5,0),(1,0) -> 120, 127 (clamp), 122, 123. Final sum=123, overflow=1 (sticky).
